// File: rtl/posit_add_arbiter_pkg.sv
// Shared types and sizing for the posit adder arbiter.
// Requester count, adder latency and credit depth are fixed here for the whole slice.
package posit_arb_defines;

  localparam int unsigned N            = 4;
  localparam int unsigned LAT          = 4;
  localparam int unsigned MAX_OUT      = 4;
  localparam int unsigned DW           = 32;
  localparam int unsigned TAG_W        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W        = $clog2(MAX_OUT + 1);
  localparam int unsigned DRAIN_CYCLES = LAT + 1;
  localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  // Head of the tag line lines up with add_done for the op accepted LAT+1 edges earlier.
  localparam int unsigned TL_DEPTH     = LAT + 2;

  typedef logic [TAG_W-1:0] arb_tag_t;

  typedef struct packed {
    logic     valid;
    arb_tag_t tag;
  } tag_entry_t;

  typedef enum logic {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  function automatic logic [N-1:0] tag_onehot(input arb_tag_t t);
    logic [N-1:0] oh;
    oh    = '0;
    oh[t] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/posit_add_arbiter_rr.sv
// Combinational round-robin pick: first valid index at or after the pointer, wrapping.
module rr_arbiter_N
  import posit_arb_defines::*;
(
  input  logic [N-1:0] i_valid,
  input  arb_tag_t     i_ptr,
  output logic [N-1:0] o_gnt,
  output arb_tag_t     o_idx,
  output logic         o_any
);

  arb_tag_t w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = arb_tag_t'((32'(i_ptr) + k) % N);
      if (!o_any && i_valid[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/posit_add_arbiter.sv
// Shares one fixed-latency posit adder among N requesters with round-robin issue,
// per-requester credits and tag-based result routing.
module posit_add_arbiter
  import posit_arb_defines::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*DW-1:0] req_in1,
  input  logic [N*DW-1:0] req_in2,
  output logic [DW-1:0]   add_in1,
  output logic [DW-1:0]   add_in2,
  output logic            add_start,
  input  logic [DW-1:0]   add_result,
  input  logic            add_inf,
  input  logic            add_zero,
  input  logic            add_done,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_result,
  output logic            rsp_inf,
  output logic            rsp_zero,
  output logic            busy,
  output logic            err
);

  arb_state_t          r_state, w_state_nxt;
  logic [DRAIN_W-1:0]  r_drain, w_drain_nxt;
  arb_tag_t            r_ptr;
  logic [CNT_W-1:0]    r_credit [N];
  tag_entry_t          r_tl [TL_DEPTH];

  logic [DW-1:0]       r_add_in1, r_add_in2;
  logic                r_add_start;
  logic [N-1:0]        r_rsp_valid;
  logic [DW-1:0]       r_rsp_result;
  logic                r_rsp_inf, r_rsp_zero;
  logic                r_busy, r_err;

  logic [N-1:0]        w_elig, w_gnt, w_inc, w_dec, w_rsp_oh;
  arb_tag_t            w_gidx;
  logic                w_gany, w_accept, w_rsp_fire, w_busy_nxt;
  tag_entry_t          w_head;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_elig[i] = req_valid[i] && (r_credit[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter_N u_rr (
    .i_valid (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gidx),
    .o_any   (w_gany)
  );

  assign w_head     = r_tl[TL_DEPTH-1];
  assign w_accept   = (r_state == RUN) && w_gany;
  assign w_rsp_fire = (r_state == RUN) && add_done && w_head.valid;
  assign w_rsp_oh   = tag_onehot(w_head.tag);
  assign w_inc      = w_accept ? w_gnt : '0;
  assign w_dec      = w_rsp_fire ? w_rsp_oh : '0;

  // Next state, drain countdown and the combinational grant strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    req_ready   = '0;
    if (r_state == DRAIN) begin
      w_drain_nxt = r_drain - DRAIN_W'(1);
      if (r_drain == DRAIN_W'(1)) begin
        w_state_nxt = RUN;
      end
    end else begin
      req_ready = w_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DRAIN;
      r_drain <= DRAIN_W'(DRAIN_CYCLES);
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Operand capture and issue strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_start <= 1'b0;
      r_add_in1   <= '0;
      r_add_in2   <= '0;
      r_ptr       <= '0;
    end else begin
      r_add_start <= w_accept;
      if (w_accept) begin
        r_add_in1 <= req_in1[{w_gidx, 5'd0} +: DW];
        r_add_in2 <= req_in2[{w_gidx, 5'd0} +: DW];
        r_ptr     <= (w_gidx == arb_tag_t'(N - 1)) ? '0 : w_gidx + arb_tag_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TL_DEPTH; i++) begin
        r_tl[i] <= '0;
      end
    end else begin
      r_tl[0] <= '{valid: w_accept, tag: w_gidx};
      for (int unsigned i = 1; i < TL_DEPTH; i++) begin
        r_tl[i] <= r_tl[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_credit[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_credit[i] <= r_credit[i] + CNT_W'(1);
        end else if (!w_inc[i] && w_dec[i]) begin
          r_credit[i] <= r_credit[i] - CNT_W'(1);
        end
      end
    end
  end

  // Response routing; a done without a matching head entry in RUN is a protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_inf    <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_fire ? w_rsp_oh : '0;
      if (w_rsp_fire) begin
        r_rsp_result <= add_result;
        r_rsp_inf    <= add_inf;
        r_rsp_zero   <= add_zero;
      end
      if ((r_state == RUN) && (add_done != w_head.valid)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == DRAIN) || w_accept || w_rsp_fire;
    for (int unsigned i = 0; i < TL_DEPTH - 1; i++) begin
      w_busy_nxt = w_busy_nxt || r_tl[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign add_in1    = r_add_in1;
  assign add_in2    = r_add_in2;
  assign add_start  = r_add_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_inf    = r_rsp_inf;
  assign rsp_zero   = r_rsp_zero;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: stand-in adder, transaction-level reference model,
// directed vector table and randomized traffic.
module tb_posit_add_arbiter;
  import posit_arb_defines::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_in1 = '0, req_in2 = '0;
  logic [31:0]     add_in1, add_in2, add_result = '0;
  logic            add_start, add_inf = 1'b0, add_zero = 1'b0, add_done = 1'b0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_result;
  logic            rsp_inf, rsp_zero, busy, err;

  posit_add_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .add_in1(add_in1), .add_in2(add_in2),
    .add_start(add_start), .add_result(add_result), .add_inf(add_inf),
    .add_zero(add_zero), .add_done(add_done), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in adder: a + b/8, so 1.0 + 1.0 gives the posit pattern for 2.0.
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    return a + (b >> 3);
  endfunction

  // Adder pipeline: start sampled at edge s gives done after edge s+LAT; no reset.
  logic        pv [LAT+1];
  logic [31:0] pa [LAT+1], pb [LAT+1];
  logic        inj_done = 1'b0;
  initial for (int k = 0; k <= LAT; k++) begin pv[k] = 1'b0; pa[k] = '0; pb[k] = '0; end
  always @(posedge clk) begin
    for (int k = LAT; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; pb[k] = pb[k-1]; end
    pv[0] = add_start; pa[0] = add_in1; pb[0] = add_in2;
    #1;
    add_done   = pv[LAT] | inj_done;
    add_result = fake_add(pa[LAT], pb[LAT]);
    add_inf    = (add_result == 32'h8000_0000);
    add_zero   = (add_result == 32'h0);
  end

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          m_ptr, m_drain, edge_n;
  int          m_credit [N];
  bit          m_in_rst, m_err;
  int          total, bad;
  int          acc_edges[$];
  int          last_acc_edge, last_rsp_edge;
  logic [N-1:0] last_rsp_valid;
  logic [31:0] last_rsp_result;
  logic        last_rsp_inf, last_rsp_zero;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock cycle: starts at a negedge with inputs applied, ends at the next negedge.
  task automatic tick();
    bit           run, head_v, err_set;
    int           g;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [31:0]  exp_res;
    bit           exp_busy;
    #1;
    run = !m_in_rst && (m_drain == 0);
    g = -1;
    exp_rdy = '0;
    if (run) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j] && m_credit[j] < MAX_OUT) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    head_v  = (q.size() > 0) && (q[0].due == edge_n + 1);
    err_set = run && (add_done != head_v);
    @(posedge clk);
    edge_n++;
    if (!m_in_rst && m_drain > 0) m_drain--;
    if (err_set) m_err = 1'b1;
    if (g >= 0) begin
      q.push_back('{due: edge_n + LAT + 2, idx: g,
                    res: fake_add(req_in1[32*g +: 32], req_in2[32*g +: 32])});
      m_credit[g]++;
      m_ptr = (g + 1) % N;
      last_acc_edge = edge_n;
      acc_edges.push_back(edge_n);
    end
    exp_rv = '0;
    exp_res = '0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_rv[q[0].idx] = 1'b1;
      exp_res = q[0].res;
      m_credit[q[0].idx]--;
      void'(q.pop_front());
    end
    exp_busy = m_in_rst || (m_drain > 0) || (q.size() > 0) || (exp_rv != '0);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv != '0) begin
      check("rsp_result", 64'(rsp_result), 64'(exp_res));
      check("rsp_inf", 64'(rsp_inf), 64'(exp_res == 32'h8000_0000));
      check("rsp_zero", 64'(rsp_zero), 64'(exp_res == 32'h0));
    end
    if (rsp_valid != '0) begin
      last_rsp_valid  = rsp_valid;
      last_rsp_result = rsp_result;
      last_rsp_inf    = rsp_inf;
      last_rsp_zero   = rsp_zero;
      last_rsp_edge   = edge_n;
    end
    check("busy", 64'(busy), 64'(exp_busy));
    check("err", 64'(err), 64'(m_err));
    @(negedge clk);
  endtask

  // Enter reset at a negedge, check outputs clear at once, hold, then release.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    m_in_rst = 1'b1;
    q.delete();
    m_ptr = 0; m_err = 1'b0; m_drain = LAT + 1;
    for (int i = 0; i < N; i++) m_credit[i] = 0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_add_start", 64'(add_start), 64'(0));
    check("rst_add_in1", 64'(add_in1), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    for (int c = 0; c < hold; c++) tick();
    rst_n = 1'b1;
    m_in_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) tick();
  endtask

  typedef struct {
    int          r;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        inf, zero;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{2, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 1'b0, 1'b0};
    vecs[1] = '{0, 32'h3F00_0000, 32'h1000_0000, 32'h4100_0000, 1'b0, 1'b0};
    vecs[2] = '{3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1, 32'h7FFF_FFF8, 32'h0000_0040, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4] = '{1, 32'hFFFF_FFF8, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b1};

    #3 rst_n = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Reset release: spurious done pulses while draining; requester 0 waits for RUN.
    req_valid = 4'b0001;
    req_in1 = {4{32'h4000_0000}};
    req_in2 = {4{32'h4000_0000}};
    for (int c = 1; c <= LAT + 1; c++) begin
      inj_done = (c == 2 || c == 4);
      tick();
    end
    inj_done = 1'b0;
    check("drain_no_err", 64'(err), 64'(0));
    idle(LAT + 4);

    // Directed single operations from the vector table.
    foreach (vecs[v]) begin
      int waited;
      req_valid = '0;
      req_valid[vecs[v].r] = 1'b1;
      req_in1[32*vecs[v].r +: 32] = vecs[v].a;
      req_in2[32*vecs[v].r +: 32] = vecs[v].b;
      last_acc_edge = -1;
      waited = 0;
      while (last_acc_edge < 0 && waited < 8) begin tick(); waited++; end
      check("vec_accepted", 64'(last_acc_edge >= 0), 64'(1));
      last_rsp_edge = -1;
      idle(LAT + 4);
      check("vec_latency", 64'(last_rsp_edge - last_acc_edge), 64'(LAT + 2));
      check("vec_onehot", 64'(last_rsp_valid), 64'(1 << vecs[v].r));
      check("vec_result", 64'(last_rsp_result), 64'(vecs[v].res));
      check("vec_inf", 64'(last_rsp_inf), 64'(vecs[v].inf));
      check("vec_zero", 64'(last_rsp_zero), 64'(vecs[v].zero));
    end

    // All requesters valid: one accept every cycle.
    acc_edges.delete();
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) tick();
    check("rr_accepts", 64'(acc_edges.size()), 64'(12));
    idle(LAT + 4);

    // Requester 1 alone: four back-to-back, then gated until its first response.
    acc_edges.delete();
    req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) tick();
    check("credit_burst", 64'(acc_edges[3] - acc_edges[0]), 64'(3));
    check("credit_resume", 64'(acc_edges[4] - acc_edges[0]), 64'(LAT + 3));
    idle(LAT + 4);

    // Spurious done in RUN: sticky err, no response, later traffic still completes.
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    idle(3);
    check("err_sticky", 64'(err), 64'(1));
    for (int c = 0; c < 200; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_in1 = {$urandom, $urandom, $urandom, $urandom};
      req_in2 = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    idle(LAT + 4);

    // Reset with three operations in flight.
    acc_edges.delete();
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) tick();
    check("inflight_3", 64'(acc_edges.size()), 64'(3));
    req_valid = '0;
    do_reset(2);
    last_rsp_edge = -1;
    idle(LAT + 10);
    check("dropped_no_rsp", 64'(last_rsp_edge), 64'(-1));
    req_valid = 4'b1111;
    for (int c = 0; c < 16; c++) tick();
    idle(LAT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
